mc_ctrl: RTL and testbench

Multi-cycle MIPS control unit: a parametrised successor to the single-cycle `co` decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives datapath enables and mux selects per state. It handshakes with a shared instruction/data memory through `mem_rdy`, with a bounded wait, and sits between the IR/ALU and the PC, register file and memory.

---
 rtl/mc_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer with bounded mem_rdy wait.
// Optional CO_OVF_EN macro adds addi with overflow-suppressed write-back.
module mc_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               ovf,
  input  logic               mem_rdy,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               reg_wr,
  output logic               mem_wr,
  output logic               mem_rd,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         npc_sel,
  output logic               alu_src,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic               bus_err,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [ALUOP_W-1:0] A_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] A_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] A_OR  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] A_LUI = ALUOP_W'(3);

  state_t         cur;
  state_t         nxt;
  logic [CW-1:0]  cnt;
  logic           ovf_q;
  logic           waiting;
  logic           tmo;

  logic is_rt;
  logic is_addu;
  logic is_subu;
  logic is_jr;
  logic is_ori;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_lui;
  logic is_j;
  logic is_jal;
  logic is_addi;
  logic legal;

  always_comb begin
    is_rt   = (op == 6'b000000);
    is_addu = is_rt && (funct == 6'b100001);
    is_subu = is_rt && (funct == 6'b100011);
    is_jr   = is_rt && (funct == 6'b001000);
    is_ori  = (op == 6'b001101);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_beq  = (op == 6'b000100);
    is_lui  = (op == 6'b001111);
    is_j    = (op == 6'b000010);
    is_jal  = (op == 6'b000011);
`ifdef CO_OVF_EN
    is_addi = (op == 6'b001000);
`else
    is_addi = 1'b0;
`endif
    legal = is_addu | is_subu | is_jr | is_ori
          | is_lw | is_sw | is_beq | is_lui
          | is_j | is_jal | is_addi;
  end

  assign waiting = (cur == S_IF) || (cur == S_MEM);
  assign tmo = (TIMEOUT != 0) && waiting
             && (cnt == TMAX) && !mem_rdy;

  always_comb begin
    nxt        = cur;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    npc_sel    = 2'b00;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = A_ADD;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    unique case (cur)
      S_IF: begin
        if (tmo) begin
          bus_err = 1'b1;
          nxt     = S_IF;
        end else begin
          mem_rd = 1'b1;
          if (mem_rdy) begin
            ir_wr = 1'b1;
            pc_wr = 1'b1;
            nxt   = S_ID;
          end
        end
      end
      S_ID: begin
        unique case (1'b1)
          is_j: begin
            pc_wr   = 1'b1;
            npc_sel = 2'b10;
            nxt     = S_IF;
          end
          is_jal: begin
            pc_wr      = 1'b1;
            npc_sel    = 2'b10;
            reg_wr     = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            nxt        = S_IF;
          end
          is_jr: begin
            pc_wr   = 1'b1;
            npc_sel = 2'b11;
            nxt     = S_IF;
          end
          !legal: begin
            illegal = 1'b1;
            nxt     = S_IF;
          end
          default: nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        alu_src = is_ori | is_lui | is_lw | is_sw | is_addi;
        ext_op  = is_lw | is_sw | is_beq | is_addi;
        unique case (1'b1)
          is_subu, is_beq: alu_op = A_SUB;
          is_ori:          alu_op = A_OR;
          is_lui:          alu_op = A_LUI;
          default:         alu_op = A_ADD;
        endcase
        if (is_beq) begin
          pc_wr   = zero;
          npc_sel = 2'b01;
          nxt     = S_IF;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        if (tmo) begin
          bus_err = 1'b1;
          nxt     = S_IF;
        end else begin
          mem_rd = is_lw;
          mem_wr = is_sw;
          if (mem_rdy) nxt = is_lw ? S_WB : S_IF;
        end
      end
      S_WB: begin
        reg_wr     = is_addi ? !ovf_q : 1'b1;
        reg_dst    = is_rt ? 2'b01 : 2'b00;
        mem_to_reg = is_lw ? 2'b01 : 2'b00;
        nxt        = S_IF;
      end
      default: nxt = S_IF;
    endcase
    // reset masks every output, including the state view
    if (rst) begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_wr     = 1'b0;
      mem_rd     = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      npc_sel    = 2'b00;
      alu_src    = 1'b0;
      ext_op     = 1'b0;
      alu_op     = A_ADD;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

  assign state = rst ? 3'd0 : 3'(cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= S_IF;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur || tmo)
        cnt <= '0;
      else if (waiting && !mem_rdy && TIMEOUT != 0)
        cnt <= cnt + 1'b1;
`ifdef CO_OVF_EN
      if (cur == S_EXE) ovf_q <= ovf;
`else
      ovf_q <= 1'b0;
`endif
    end
  end

`ifndef CO_OVF_EN
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction cycle plans from the
// instruction rules, randomized opcodes and memory waits, TIMEOUT=4.
module tb_mc_ctrl;

  localparam int TO = 4;
  localparam int AW = 3;

  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_JR   = 2;
  localparam int C_ORI  = 3;
  localparam int C_LW   = 4;
  localparam int C_SW   = 5;
  localparam int C_BEQ  = 6;
  localparam int C_LUI  = 7;
  localparam int C_J    = 8;
  localparam int C_JAL  = 9;
  localparam int C_ADDI = 10;
  localparam int C_ILL  = 11;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
    logic [1:0] reg_dst;
    logic [1:0] m2r;
    logic [1:0] npc;
    logic       alu_src;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       ill;
    logic       berr;
  } rec_t;

  logic          clk;
  logic          rst;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic          zero;
  logic          ovf;
  logic          mem_rdy;
  logic          pc_wr;
  logic          ir_wr;
  logic          reg_wr;
  logic          mem_wr;
  logic          mem_rd;
  logic [1:0]    reg_dst;
  logic [1:0]    mem_to_reg;
  logic [1:0]    npc_sel;
  logic          alu_src;
  logic          ext_op;
  logic [AW-1:0] alu_op;
  logic          illegal;
  logic          bus_err;
  logic [2:0]    state;

  rec_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  mc_ctrl #(.TIMEOUT(TO), .ALUOP_W(AW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zero(zero), .ovf(ovf), .mem_rdy(mem_rdy),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
    .mem_wr(mem_wr), .mem_rd(mem_rd),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .npc_sel(npc_sel), .alu_src(alu_src),
    .ext_op(ext_op), .alu_op(alu_op),
    .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: one expected record per cycle, sampled mid-cycle
  always @(negedge clk) begin
    rec_t g;
    rec_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{st: state, pc_wr: pc_wr, ir_wr: ir_wr,
            reg_wr: reg_wr, mem_wr: mem_wr, mem_rd: mem_rd,
            reg_dst: reg_dst, m2r: mem_to_reg,
            npc: npc_sel, alu_src: alu_src,
            ext_op: ext_op, alu_op: alu_op,
            ill: illegal, berr: bus_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle%0d outputs got=%h want=%h (state got %0d want %0d)",
                 cyc, g, e, g.st, e.st);
      end
    end
  end

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) begin
      if (f == 6'b100001) return C_ADDU;
      if (f == 6'b100011) return C_SUBU;
      if (f == 6'b001000) return C_JR;
      return C_ILL;
    end
    if (o == 6'b001101) return C_ORI;
    if (o == 6'b100011) return C_LW;
    if (o == 6'b101011) return C_SW;
    if (o == 6'b000100) return C_BEQ;
    if (o == 6'b001111) return C_LUI;
    if (o == 6'b000010) return C_J;
    if (o == 6'b000011) return C_JAL;
`ifdef CO_OVF_EN
    if (o == 6'b001000) return C_ADDI;
`endif
    return C_ILL;
  endfunction

  task automatic emit(input rec_t e, input logic rdy, input logic r);
    rst     = r;
    mem_rdy = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rec_t e;
    e = '0;
    emit(e, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // one instruction: wf / wm low mem_rdy cycles before fetch / data ready
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int wf, input int wm,
                           input logic z, input logic v);
    int   c;
    rec_t e;
    c     = classify(o, f);
    op    = o;
    funct = f;
    zero  = z;
    ovf   = v;
    for (int i = 0; i < wf; i++) begin
      e    = '0;
      e.st = 3'd0;
      if (i % (TO + 1) == TO) e.berr = 1'b1;
      else e.mem_rd = 1'b1;
      emit(e, 1'b0, 1'b0);
    end
    e        = '0;
    e.mem_rd = 1'b1;
    e.ir_wr  = 1'b1;
    e.pc_wr  = 1'b1;
    emit(e, 1'b1, 1'b0);

    e    = '0;
    e.st = 3'd1;
    if (c == C_J || c == C_JAL) begin
      e.pc_wr = 1'b1;
      e.npc   = 2'b10;
      if (c == C_JAL) begin
        e.reg_wr  = 1'b1;
        e.reg_dst = 2'b10;
        e.m2r     = 2'b10;
      end
    end else if (c == C_JR) begin
      e.pc_wr = 1'b1;
      e.npc   = 2'b11;
    end else if (c == C_ILL) begin
      e.ill = 1'b1;
    end
    emit(e, 1'($urandom_range(0, 1)), 1'b0);
    if (c == C_J || c == C_JAL || c == C_JR || c == C_ILL) return;

    e         = '0;
    e.st      = 3'd2;
    e.alu_src = (c == C_ORI || c == C_LUI || c == C_LW
              || c == C_SW || c == C_ADDI);
    e.ext_op  = (c == C_LW || c == C_SW || c == C_BEQ || c == C_ADDI);
    if (c == C_SUBU || c == C_BEQ) e.alu_op = 3'd1;
    else if (c == C_ORI) e.alu_op = 3'd2;
    else if (c == C_LUI) e.alu_op = 3'd3;
    if (c == C_BEQ) begin
      e.pc_wr = z;
      e.npc   = 2'b01;
    end
    emit(e, 1'($urandom_range(0, 1)), 1'b0);
    if (c == C_BEQ) return;

    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i < wm; i++) begin
        e    = '0;
        e.st = 3'd3;
        if (i % (TO + 1) == TO) begin
          e.berr = 1'b1;
          emit(e, 1'b0, 1'b0);
          return;
        end
        e.mem_rd = (c == C_LW);
        e.mem_wr = (c == C_SW);
        emit(e, 1'b0, 1'b0);
      end
      e        = '0;
      e.st     = 3'd3;
      e.mem_rd = (c == C_LW);
      e.mem_wr = (c == C_SW);
      emit(e, 1'b1, 1'b0);
      if (c == C_SW) return;
    end

    e         = '0;
    e.st      = 3'd4;
    e.reg_wr  = (c == C_ADDI) ? !v : 1'b1;
    e.reg_dst = (o == 6'b000000) ? 2'b01 : 2'b00;
    e.m2r     = (c == C_LW) ? 2'b01 : 2'b00;
    emit(e, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // fetch and decode an addu, then reset before it executes
  task automatic abort_by_reset();
    rec_t e;
    op       = 6'b000000;
    funct    = 6'b100001;
    e        = '0;
    e.mem_rd = 1'b1;
    e.ir_wr  = 1'b1;
    e.pc_wr  = 1'b1;
    emit(e, 1'b1, 1'b0);
    e    = '0;
    e.st = 3'd1;
    emit(e, 1'b1, 1'b0);
    reset_cycle();
  endtask

  logic [5:0] tops[11];
  logic [5:0] tfun[11];

  initial begin
    int k;
    int wf;
    int wm;
    tops = '{6'b000000, 6'b000000, 6'b000000, 6'b001101,
             6'b100011, 6'b101011, 6'b000100, 6'b001111,
             6'b000010, 6'b000011, 6'b001000};
    tfun = '{6'b100001, 6'b100011, 6'b001000, 6'b000000,
             6'b000000, 6'b000000, 6'b000000, 6'b000000,
             6'b000000, 6'b000000, 6'b000000};
    rst     = 1'b1;
    op      = '0;
    funct   = '0;
    zero    = 1'b0;
    ovf     = 1'b0;
    mem_rdy = 1'b0;
    @(posedge clk);
    #1;
    reset_cycle();
    reset_cycle();

    run_instr(6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0);
    run_instr(6'b100011, 6'b000000, 0, 3, 1'b0, 1'b0);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1, 1'b0);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0, 1'b0);
    run_instr(6'b000011, 6'b000000, 0, 0, 1'b0, 1'b0);
    run_instr(6'b101011, 6'b000000, 2, 0, 1'b0, 1'b0);
    run_instr(6'b000010, 6'b000000, 7, 0, 1'b0, 1'b0);
    run_instr(6'b000000, 6'b100011, 4, 0, 1'b0, 1'b0);
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0, 1'b0);
    run_instr(6'b001000, 6'b000000, 0, 0, 1'b0, 1'b1);
    run_instr(6'b001000, 6'b000000, 0, 0, 1'b0, 1'b0);
    run_instr(6'b100011, 6'b000000, 0, 6, 1'b0, 1'b0);
    run_instr(6'b001111, 6'b000000, 9, 0, 1'b0, 1'b0);
    abort_by_reset();
    run_instr(6'b001101, 6'b000000, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 13);
      wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 0;
      wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 11) : 0;
      if (k < 11)
        run_instr(tops[k], tfun[k], wf, wm,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        run_instr(6'($urandom), 6'($urandom), wf, wm,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) reset_cycle();
    end

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
